hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
// - Pipeline hazard resolver for the 5-stage scalar/vector core. It consumes the
//   controller's hazard interface (RegWriteM, MemtoRegE, PCWrPendingF) and drives
//   FlushE back to the controller.
// - Generates stalls, flushes and E-stage operand forwarding selects.
// - Tracks register addresses D->E->M->W internally.
// - Sequences a multi-cycle MULV occupancy of the E stage.
// PARAMETERS
// - REG_ADDR_W  4  width of register-file addresses
// - MULV_LAT    4  cycles a MULV occupies E; must be >=1; 1 means no stall
// PORTS
// - clk           in   1           core clock, rising edge
// - reset         in   1           synchronous, active-high
// - RA1D, RA2D    in   REG_ADDR_W  source regs (Rn, Rm) of instr in D
// - WA3D          in   REG_ADDR_W  destination reg (Rd) of instr in D
// - RegWriteM     in   1           gated reg write of instr in M
// - RegWriteW     in   1           reg write of instr in W
// - MemtoRegE     in   1           instr in E is a load (LDR)
// - PCWrPendingF  in   1           PC write pending in D/E/M
// - PCSrcW        in   1           PC written in W
// - BranchTakenE  in   1           branch resolved taken in E
// - MulVE         in   1           instr in E is a MULV
// - StallF        out  1           hold PC register
// - StallD        out  1           hold F/D register
// - StallE        out  1           hold D/E register
// - FlushD        out  1           clear F/D register
// - FlushE        out  1           clear D/E register
// - ForwardAE     out  2           SrcA select: 00 regfile, 01 ResultW, 10 ALUResultM
// - ForwardBE     out  2           SrcB select, same encoding
// BEHAVIOUR
// - Internal registers RA1E, RA2E, WA3E, ValidE, WA3M, ValidM, WA3W, ValidW are
//   all 0 on reset.
//   - D->E: hold on StallE. On FlushE, ValidE <= 0. Otherwise ValidE <= 1.
//   - E->M: when StallE, ValidM <= 0 (bubble). Otherwise copy from E.
//   - M->W: copy every cycle.
// - Forwarding (combinational from the registered addresses), for X = 1/A, 2/B:
//   - 10 if ValidM & RegWriteM & RAXE==WA3M.
//   - else 01 if ValidW & RegWriteW & RAXE==WA3W.
//   - else 00.
//   - M has priority over W.
//   - An address of 4'hF never forwards; PC reads use the separate path.
// - LDRstall = ValidE & MemtoRegE & (RA1D==WA3E | RA2D==WA3E).
// - StallF = LDRstall | PCWrPendingF | StallE.
// - StallD = LDRstall | StallE.
// - FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
// - FlushE = (LDRstall | BranchTakenE) & ~StallE. FlushE is never asserted while
//   E is held.
// - MULV FSM, states IDLE and BUSY, counter cnt (clog2(MULV_LAT)+1 bits):
//   - IDLE:
//     - If MulVE & MULV_LAT>1: StallE=1, cnt<=1, go to BUSY.
//     - Otherwise StallE=0.
//   - BUSY:
//     - If cnt==MULV_LAT-1: StallE=0, go to IDLE. This is the last cycle; the
//       instr leaves E at the edge.
//     - Otherwise StallE=1, cnt<=cnt+1.
//   - Result: exactly MULV_LAT-1 stall cycles per MULV.
//   - Back-to-back MULVs retrigger from IDLE with no gap cycle.
// - Reset values:
//   - All outputs are 0 in the first cycle after reset with inputs at 0.
//   - The FSM is in IDLE and cnt is 0.
// - Reset mid-MULV: the FSM returns to IDLE at the next edge and StallE drops the
//   same cycle.
// - Simultaneous events:
//   - Branch flush and load stall in the same cycle: both FlushD and FlushE are
//     asserted, and StallF/StallD are asserted too.
//   - The datapath gives flush priority over stall on the same register.
// STRUCTURE
// - hazard_pkg holds:
//   - fwd_sel_t enum {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}
//   - vmul_state_t enum {VM_IDLE, VM_BUSY}
//   - localparam PC_REG = 4'hF
// - Sub-module hazard_vmul_fsm (clk, reset, MulVE -> StallE) holds the counter
//   and the FSM.
// - Address pipeline, forwarding and stall/flush equations live in the top level.
// TESTING
// - Forward from M: ADD R1 in M (RegWriteM=1, WA3M=1), RA1E=1 -> ForwardAE=10,
//   ForwardBE=00.
// - M/W priority: WA3M=WA3W=3, both writes on, RA2E=3 -> ForwardBE=10. With
//   RegWriteM=0 -> ForwardBE=01.
// - Load-use:
//   - Stimulus: LDR R2 in E (MemtoRegE=1, WA3E=2), RA2D=2.
//   - One cycle with StallF=StallD=FlushE=1.
//   - Next cycle ForwardBE=01, with no stall.
// - Branch: BranchTakenE=1 -> FlushD=FlushE=1 for that cycle only.
//   PCWrPendingF=1 -> StallF=FlushD=1.
// - MULV, MULV_LAT=4:
//   - Single MULV: StallF/D/E high for exactly 3 cycles, FlushE=0 throughout.
//   - Back-to-back MULVs: 3 stall cycles, 1 release cycle, then 3 more.
// - Reset in BUSY: StallE=0 the next cycle.
// - PC register: WA3M=RA1E=4'hF with RegWriteM=1 -> ForwardAE=00.

Source files
------------

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard resolver.
//   fwd_sel_t    : E-stage operand source select (register file / WB / MEM)
//   vmul_state_t : states of the multi-cycle MULV occupancy sequencer
//   PC_REG       : register address that aliases the PC; never forwarded
// ---------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        VM_IDLE,
        VM_BUSY
    } vmul_state_t;

    localparam logic [3:0] PC_REG = 4'hF;

endpackage

// File: rtl/hazard_if.sv
// ---------------------------------------------------------------------------
// hazard_if
// Bundle between the core controller/datapath and the hazard unit.
//   master : controller/datapath side (drives D-stage addresses and the
//            per-stage status flags, receives stall/flush/forward controls)
//   slave  : hazard unit side
// Inputs to the hazard unit:
//   RA1D, RA2D, WA3D   register addresses of the instruction in D
//   RegWriteM/W        register write of the instruction in M / W
//   MemtoRegE          instruction in E is a load
//   PCWrPendingF       PC write pending in D/E/M
//   PCSrcW             PC written in W
//   BranchTakenE       branch resolved taken in E
//   MulVE              instruction in E is a MULV
// Outputs of the hazard unit:
//   StallF/D/E, FlushD/E, ForwardAE/BE
// ---------------------------------------------------------------------------
interface hazard_if #(
    parameter int REG_ADDR_W = 4
);
    logic [REG_ADDR_W-1:0] RA1D;
    logic [REG_ADDR_W-1:0] RA2D;
    logic [REG_ADDR_W-1:0] WA3D;
    logic                  RegWriteM;
    logic                  RegWriteW;
    logic                  MemtoRegE;
    logic                  PCWrPendingF;
    logic                  PCSrcW;
    logic                  BranchTakenE;
    logic                  MulVE;

    logic                  StallF;
    logic                  StallD;
    logic                  StallE;
    logic                  FlushD;
    logic                  FlushE;
    logic [1:0]            ForwardAE;
    logic [1:0]            ForwardBE;

    modport master (
        output RA1D, RA2D, WA3D, RegWriteM, RegWriteW, MemtoRegE,
               PCWrPendingF, PCSrcW, BranchTakenE, MulVE,
        input  StallF, StallD, StallE, FlushD, FlushE, ForwardAE, ForwardBE
    );

    modport slave (
        input  RA1D, RA2D, WA3D, RegWriteM, RegWriteW, MemtoRegE,
               PCWrPendingF, PCSrcW, BranchTakenE, MulVE,
        output StallF, StallD, StallE, FlushD, FlushE, ForwardAE, ForwardBE
    );
endinterface

// File: rtl/hazard_vmul_fsm.sv
// ---------------------------------------------------------------------------
// hazard_vmul_fsm
// Holds a MULV in the E stage for MULV_LAT cycles, i.e. asserts StallE for
// exactly MULV_LAT-1 cycles per MULV. A new MULV arriving in E right after
// the release cycle retriggers immediately from IDLE.
//   clk    in  core clock
//   reset  in  synchronous active-high reset
//   MulVE  in  instruction in E is a MULV
//   StallE out hold the D/E register (and everything upstream)
// ---------------------------------------------------------------------------
module hazard_vmul_fsm
    import hazard_pkg::*;
#(
    parameter int MULV_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic MulVE,
    output logic StallE
);

    localparam int                CNT_W    = $clog2(MULV_LAT) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MULV_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam bit                MULTI    = (MULV_LAT > 1);

    vmul_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_e;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= VM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The first occupancy cycle is counted in IDLE, so BUSY only needs to
    // run until cnt reaches MULV_LAT-1, which is the release cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_e = 1'b0;
        case (state_q)
            VM_IDLE: begin
                if (MulVE && MULTI) begin
                    stall_e = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = VM_BUSY;
                end
            end
            VM_BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = VM_IDLE;
                end else begin
                    stall_e = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = VM_IDLE;
            end
        endcase
    end

    assign StallE = stall_e;

endmodule

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard resolver for the 5-stage scalar/vector core.
//   clk    in  core clock
//   reset  in  synchronous active-high reset
//   hz     hazard_if.slave : D-stage addresses and stage flags in,
//          StallF/D/E, FlushD/E, ForwardAE/BE out
// Tracks register addresses D->E->M->W, selects E-stage operand forwarding,
// detects load-use hazards, generates branch/PC flushes, and delegates the
// multi-cycle MULV occupancy of E to hazard_vmul_fsm.
// ---------------------------------------------------------------------------
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int MULV_LAT   = 4
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  hz
);

    localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_REG);

    // Address pipeline state
    logic [REG_ADDR_W-1:0] ra1e_q, ra1e_d;
    logic [REG_ADDR_W-1:0] ra2e_q, ra2e_d;
    logic [REG_ADDR_W-1:0] wa3e_q, wa3e_d;
    logic                  valid_e_q, valid_e_d;
    logic [REG_ADDR_W-1:0] wa3m_q, wa3m_d;
    logic                  valid_m_q, valid_m_d;
    logic [REG_ADDR_W-1:0] wa3w_q, wa3w_d;
    logic                  valid_w_q, valid_w_d;

    logic stall_e;
    logic ldr_stall;
    logic flush_e;

    hazard_vmul_fsm #(
        .MULV_LAT (MULV_LAT)
    ) u_vmul_fsm (
        .clk    (clk),
        .reset  (reset),
        .MulVE  (hz.MulVE),
        .StallE (stall_e)
    );

    // Load-use: the D instruction reads the register a load in E is about to
    // produce; hold D for one cycle and push a bubble into E.
    assign ldr_stall = valid_e_q & hz.MemtoRegE &
                       ((hz.RA1D == wa3e_q) | (hz.RA2D == wa3e_q));

    // E is never flushed while it is being held by a MULV.
    assign flush_e = (ldr_stall | hz.BranchTakenE) & ~stall_e;

    always_comb begin
        ra1e_d    = ra1e_q;
        ra2e_d    = ra2e_q;
        wa3e_d    = wa3e_q;
        valid_e_d = valid_e_q;
        if (!stall_e) begin
            ra1e_d    = hz.RA1D;
            ra2e_d    = hz.RA2D;
            wa3e_d    = hz.WA3D;
            valid_e_d = ~flush_e;
        end

        // While E is held the instruction in E does not advance, so M
        // receives a bubble; its address is left as-is since it is invalid.
        wa3m_d    = wa3m_q;
        valid_m_d = 1'b0;
        if (!stall_e) begin
            wa3m_d    = wa3e_q;
            valid_m_d = valid_e_q;
        end

        wa3w_d    = wa3m_q;
        valid_w_d = valid_m_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ra1e_q    <= '0;
            ra2e_q    <= '0;
            wa3e_q    <= '0;
            valid_e_q <= 1'b0;
            wa3m_q    <= '0;
            valid_m_q <= 1'b0;
            wa3w_q    <= '0;
            valid_w_q <= 1'b0;
        end else begin
            ra1e_q    <= ra1e_d;
            ra2e_q    <= ra2e_d;
            wa3e_q    <= wa3e_d;
            valid_e_q <= valid_e_d;
            wa3m_q    <= wa3m_d;
            valid_m_q <= valid_m_d;
            wa3w_q    <= wa3w_d;
            valid_w_q <= valid_w_d;
        end
    end

    // Forwarding for both E-stage source operands; M (youngest) wins over W.
    // The PC alias is served by its own datapath path and never forwarded.
    logic [REG_ADDR_W-1:0] ra_e    [2];
    fwd_sel_t              fwd_sel [2];

    assign ra_e[0] = ra1e_q;
    assign ra_e[1] = ra2e_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic not_pc;
            logic hit_m;
            logic hit_w;
            assign not_pc = (ra_e[gi] != PC_ADDR);
            assign hit_m  = valid_m_q & hz.RegWriteM & (ra_e[gi] == wa3m_q) & not_pc;
            assign hit_w  = valid_w_q & hz.RegWriteW & (ra_e[gi] == wa3w_q) & not_pc;
            assign fwd_sel[gi] = hit_m ? FWD_MEM : (hit_w ? FWD_WB : FWD_RF);
        end
    endgenerate

    assign hz.ForwardAE = fwd_sel[0];
    assign hz.ForwardBE = fwd_sel[1];
    assign hz.StallE    = stall_e;
    assign hz.StallD    = ldr_stall | stall_e;
    assign hz.StallF    = ldr_stall | hz.PCWrPendingF | stall_e;
    assign hz.FlushD    = hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE;
    assign hz.FlushE    = flush_e;

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
// Directed bench for hazard_unit (REG_ADDR_W=4, MULV_LAT=4). Inputs change
// 1 time unit after the rising edge; outputs are sampled before the next edge.
// ---------------------------------------------------------------------------
module tb_hazard_unit;

    logic clk;
    logic reset;
    int   n_err;
    int   n_chk;

    hazard_if #(.REG_ADDR_W(4)) hi ();

    hazard_unit #(
        .REG_ADDR_W (4),
        .MULV_LAT   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3);
        hi.RA1D = ra1;
        hi.RA2D = ra2;
        hi.WA3D = wa3;
    endtask

    task automatic clr_ctl();
        hi.RegWriteM    = 1'b0;
        hi.RegWriteW    = 1'b0;
        hi.MemtoRegE    = 1'b0;
        hi.PCWrPendingF = 1'b0;
        hi.PCSrcW       = 1'b0;
        hi.BranchTakenE = 1'b0;
        hi.MulVE        = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_chk++;
        $display("[%0t] check %s obs=%b exp=%b", $time, tag, obs, exp);
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        reset = 1'b1;
        clr_ctl();
        set_d(4'd0, 4'd0, 4'd0);
        repeat (3) tick();

        // ---- Reset state
        reset = 1'b0;
        #1;
        chk("rst_StallF", {1'b0, hi.StallF}, 2'b00);
        chk("rst_StallD", {1'b0, hi.StallD}, 2'b00);
        chk("rst_StallE", {1'b0, hi.StallE}, 2'b00);
        chk("rst_FlushD", {1'b0, hi.FlushD}, 2'b00);
        chk("rst_FlushE", {1'b0, hi.FlushE}, 2'b00);
        chk("rst_FwdA",   hi.ForwardAE,      2'b00);
        chk("rst_FwdB",   hi.ForwardBE,      2'b00);
        tick();

        // ---- Forward from M: ADD R1 then a reader of R1
        set_d(4'd5, 4'd6, 4'd1);
        tick();
        set_d(4'd1, 4'd7, 4'd8);
        tick();
        set_d(4'd0, 4'd0, 4'd0);
        hi.RegWriteM = 1'b1;
        #1;
        chk("fwdM_A", hi.ForwardAE, 2'b10);
        chk("fwdM_B", hi.ForwardBE, 2'b00);
        hi.RegWriteM = 1'b0;

        // ---- M/W priority: two writers of R3, then a reader of R3 on B
        set_d(4'd0, 4'd0, 4'd3);
        tick();
        set_d(4'd0, 4'd0, 4'd3);
        tick();
        set_d(4'd0, 4'd3, 4'd9);
        tick();
        set_d(4'd0, 4'd0, 4'd0);
        hi.RegWriteM = 1'b1;
        hi.RegWriteW = 1'b1;
        #1;
        chk("prio_B_M", hi.ForwardBE, 2'b10);
        chk("prio_A",   hi.ForwardAE, 2'b00);
        hi.RegWriteM = 1'b0;
        #1;
        chk("prio_B_W", hi.ForwardBE, 2'b01);
        hi.RegWriteW = 1'b0;

        // ---- Load-use: LDR R2 in E, D reads R2
        set_d(4'd0, 4'd0, 4'd2);
        tick();
        set_d(4'd4, 4'd2, 4'd5);
        hi.MemtoRegE = 1'b1;
        #1;
        chk("ldr_StallF", {1'b0, hi.StallF}, 2'b01);
        chk("ldr_StallD", {1'b0, hi.StallD}, 2'b01);
        chk("ldr_FlushE", {1'b0, hi.FlushE}, 2'b01);
        chk("ldr_StallE", {1'b0, hi.StallE}, 2'b00);
        chk("ldr_FlushD", {1'b0, hi.FlushD}, 2'b00);
        tick();
        hi.MemtoRegE = 1'b0;
        #1;
        chk("ldr_bub_StallF", {1'b0, hi.StallF}, 2'b00);
        chk("ldr_bub_FlushE", {1'b0, hi.FlushE}, 2'b00);
        tick();
        hi.RegWriteW = 1'b1;
        #1;
        chk("ldr_use_FwdB",   hi.ForwardBE,      2'b01);
        chk("ldr_use_FwdA",   hi.ForwardAE,      2'b00);
        chk("ldr_use_StallF", {1'b0, hi.StallF}, 2'b00);
        hi.RegWriteW = 1'b0;

        // ---- Branch taken in E, then PC write pending
        set_d(4'd0, 4'd0, 4'd0);
        hi.BranchTakenE = 1'b1;
        #1;
        chk("br_FlushD", {1'b0, hi.FlushD}, 2'b01);
        chk("br_FlushE", {1'b0, hi.FlushE}, 2'b01);
        chk("br_StallF", {1'b0, hi.StallF}, 2'b00);
        tick();
        hi.BranchTakenE = 1'b0;
        #1;
        chk("br_next_FlushD", {1'b0, hi.FlushD}, 2'b00);
        chk("br_next_FlushE", {1'b0, hi.FlushE}, 2'b00);
        hi.PCWrPendingF = 1'b1;
        #1;
        chk("pcw_StallF", {1'b0, hi.StallF}, 2'b01);
        chk("pcw_FlushD", {1'b0, hi.FlushD}, 2'b01);
        chk("pcw_StallD", {1'b0, hi.StallD}, 2'b00);
        chk("pcw_FlushE", {1'b0, hi.FlushE}, 2'b00);
        hi.PCWrPendingF = 1'b0;

        // ---- PCSrcW alone flushes D
        hi.PCSrcW = 1'b1;
        #1;
        chk("pcsrc_FlushD", {1'b0, hi.FlushD}, 2'b01);
        chk("pcsrc_FlushE", {1'b0, hi.FlushE}, 2'b00);
        hi.PCSrcW = 1'b0;

        // ---- Branch flush and load stall together
        set_d(4'd0, 4'd0, 4'd6);
        tick();
        set_d(4'd6, 4'd0, 4'd7);
        hi.MemtoRegE    = 1'b1;
        hi.BranchTakenE = 1'b1;
        #1;
        chk("both_FlushD", {1'b0, hi.FlushD}, 2'b01);
        chk("both_FlushE", {1'b0, hi.FlushE}, 2'b01);
        chk("both_StallF", {1'b0, hi.StallF}, 2'b01);
        chk("both_StallD", {1'b0, hi.StallD}, 2'b01);
        clr_ctl();

        // ---- PC register never forwards
        set_d(4'd0, 4'd0, 4'hF);
        tick();
        set_d(4'hF, 4'd0, 4'd0);
        tick();
        set_d(4'd0, 4'd0, 4'd0);
        hi.RegWriteM = 1'b1;
        #1;
        chk("pc_FwdA", hi.ForwardAE, 2'b00);
        chk("pc_FwdB", hi.ForwardBE, 2'b00);
        hi.RegWriteM = 1'b0;
        tick();

        // ---- Single MULV: three stall cycles then release
        hi.MulVE = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mulv1_StallE_%0d", i), {1'b0, hi.StallE}, (i < 3) ? 2'b01 : 2'b00);
            chk($sformatf("mulv1_StallF_%0d", i), {1'b0, hi.StallF}, (i < 3) ? 2'b01 : 2'b00);
            chk($sformatf("mulv1_StallD_%0d", i), {1'b0, hi.StallD}, (i < 3) ? 2'b01 : 2'b00);
            chk($sformatf("mulv1_FlushE_%0d", i), {1'b0, hi.FlushE}, 2'b00);
            if (i == 3) hi.MulVE = 1'b0;
            tick();
        end
        chk("mulv1_after_StallE", {1'b0, hi.StallE}, 2'b00);

        // ---- Back-to-back MULVs: 3 stall, 1 release, 3 stall, 1 release
        hi.MulVE = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mulv2_StallE_%0d", i), {1'b0, hi.StallE}, ((i % 4) != 3) ? 2'b01 : 2'b00);
            if (i == 7) hi.MulVE = 1'b0;
            tick();
        end
        chk("mulv2_after_StallE", {1'b0, hi.StallE}, 2'b00);

        // ---- Reset while BUSY
        hi.MulVE = 1'b1;
        #1;
        chk("rstb_StallE_0", {1'b0, hi.StallE}, 2'b01);
        tick();
        chk("rstb_StallE_1", {1'b0, hi.StallE}, 2'b01);
        reset    = 1'b1;
        hi.MulVE = 1'b0;
        tick();
        chk("rstb_StallE_after", {1'b0, hi.StallE}, 2'b00);
        chk("rstb_StallF_after", {1'b0, hi.StallF}, 2'b00);
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
